bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
- Upstream feeder for the serial pattern-detector FSM.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a single serial line, which drives the detector's `in` input.
- A one-entry holding buffer lets back-to-back words stream with no idle gap between them.
- Flags word boundaries so downstream logic can align detections to words.

Parameters:
- WIDTH, 8, word width in bits (≥2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, level driven on sout whenever sout_valid=0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- din  input  WIDTH  parallel word.
- din_valid  input  1  din holds a word.
- din_ready  output  1  block can take a word this cycle.
- sout  output  1  serial bit, registered.
- sout_valid  output  1  sout carries a data bit this cycle.
- sout_last  output  1  sout is the final bit of the current word.
- busy  output  1  sout_valid OR hold buffer occupied.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: sout=IDLE_BIT, sout_valid=0, sout_last=0, busy=0, din_ready=1, hold buffer empty, state=IDLE, bit counter=0.
- Handshake:
  - A word is accepted on any rising edge where din_valid=1 and din_ready=1.
  - din_ready = NOT hold_full. It is a function of registered state only, with no combinational path from din_valid.
- State machine:
  - IDLE: shifter empty.
    - On accept, load din into the shift register, set counter=0, go to SHIFT.
    - The first bit appears on sout in the cycle after the accept edge (latency 1).
  - SHIFT: one bit is presented per cycle for WIDTH cycles; sout_valid=1 throughout.
    - A word accepted during SHIFT goes into the hold buffer.
    - On the edge that ends the last bit (counter=WIDTH-1):
      - hold_full: load the hold word into the shifter and clear hold_full. The next word's first bit follows with no gap.
      - else, accept on the same edge: load din directly into the shifter. No gap.
      - else: go to IDLE; sout=IDLE_BIT, sout_valid=0.
- Simultaneous events: if hold_full at the last-bit edge, din_ready=0 for that cycle, so no word is taken that edge. The buffer drains first.
- sout_last=1 exactly when sout_valid=1 and counter=WIDTH-1.
- Bit order: MSB_FIRST=1 shifts left and outputs the MSB; MSB_FIRST=0 shifts right and outputs the LSB.
- Counter is ceil(log2(WIDTH)) bits and wraps to 0 on each new load.
- Reset mid-word: the word in flight and the held word are discarded. Outputs return to reset values asynchronously. No partial word is resumed.
- din is sampled only on the accept edge; changes to din at other times are ignored.

Decomposition:
- Shared package `serializer_pkg`:
  - State enum: IDLE, SHIFT.
  - Default WIDTH / IDLE_BIT constants.
  - Counter-width function clog2.
- One natural sub-module, `ser_hold_reg`: a one-entry word buffer with load/unload/full. The shifter FSM stays in bit_serializer.

Test Plan:
- Single word: reset, then din=8'hB1 with valid for one accepted cycle.
  - sout = 1,0,1,1,0,0,0,1 on the 8 cycles after accept.
  - sout_last on the 8th cycle.
  - Then sout_valid=0 and sout=0.
- Back-to-back: 8'hB1 accepted, then 8'h0F held valid.
  - Second word is accepted into hold on the next cycle; din_ready=0 until the drain.
  - 16 contiguous valid bits: 10110001 00001111.
  - sout_last on bits 8 and 16; no gap.
- LSB-first: MSB_FIRST=0, din=8'h01 -> sout = 1,0,0,0,0,0,0,0.
- Reset mid-operation: assert reset during bit 4 of 8'hFF, with 8'hAA held.
  - Outputs reset immediately; din_ready=1.
  - After release, sending 8'h81 yields exactly 1,0,0,0,0,0,0,1 with no residue of 8'hAA.
- Backpressure: keep din_valid=1 with changing din while hold_full.
  - No word is accepted while din_ready=0.
  - Only the values present on accept edges appear on sout.
- Chain with the detector: send 8'h88 then 8'h80 (stream 10001000 10000000).
  - Detector out pulses on the 5th bit of the first word.
  - No pulse while sout idles at 0 after the last word.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and helpers for the bit serializer and its hold buffer.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int   DEF_WIDTH    = 8;
  localparam logic DEF_IDLE_BIT = 1'b0;

  // Bits needed to count 0..v-1; never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry word buffer that parks a word accepted while the shifter is busy.
module ser_hold_reg
  import serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             unload_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o
);

  logic             full_q;
  logic             full_d;
  logic [WIDTH-1:0] data_q;

  // Occupancy: unload empties the slot, load fills it (load wins if both).
  always_comb begin
    full_d = full_q;
    if (unload_i) full_d = 1'b0;
    if (load_i)   full_d = 1'b1;
  end

  // Occupancy flag; cleared by reset so any parked word is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full_q <= 1'b0;
    else     full_q <= full_d;
  end

  // Word storage; contents are meaningless while the slot is empty.
  always_ff @(posedge clk) begin
    if (load_i) data_q <= data_i;
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a valid/ready input and a one-word hold
// buffer so consecutive words stream out with no idle bit between them.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int   WIDTH     = DEF_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int            CW       = clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;

  logic             accept;
  logic             hold_load;
  logic             hold_unload;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;

  // Advance the shifter by one bit in the configured direction.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
    else           return {1'b0, v[WIDTH-1:1]};
  endfunction

  // The bit the shifter currently presents.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return v[WIDTH-1];
    else           return v[0];
  endfunction

  // Ready depends only on the hold slot, never on din_valid.
  assign din_ready = ~hold_full;
  assign accept    = din_valid & din_ready;

  ser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst      (reset),
    .load_i   (hold_load),
    .unload_i (hold_unload),
    .data_i   (din),
    .data_o   (hold_data),
    .full_o   (hold_full)
  );

  // Shifter FSM: load on accept, shift WIDTH bits, then chain the next word
  // (held word first, else a word arriving on the same edge) or go idle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    hold_load   = 1'b0;
    hold_unload = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (hold_full) begin
            shreg_d     = hold_data;
            hold_unload = 1'b1;
          end else if (accept) begin
            shreg_d = din;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shreg_d   = shift_once(shreg_q);
          cnt_d     = cnt_q + CW'(1);
          hold_load = accept;
        end
      end
      default: state_d = IDLE;
    endcase
    sout_d = (state_d == SHIFT) ? head_bit(shreg_d) : IDLE_BIT;
  end

  // Control state and the registered serial bit; reset abandons any word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sout_q  <= IDLE_BIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
    end
  end

  // Shift data; only observable while in SHIFT, so it carries no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign sout       = sout_q;
  assign sout_valid = (state_q == SHIFT);
  assign sout_last  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign busy       = sout_valid | hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against a word-queue reference model.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;

  logic rdy_m, sout_m, sv_m, sl_m, busy_m;
  logic rdy_l, sout_l, sv_l, sl_l, busy_l;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .sout(sout_m), .sout_valid(sv_m),
    .sout_last(sl_m), .busy(busy_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .sout(sout_l), .sout_valid(sv_l),
    .sout_last(sl_l), .busy(busy_l)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: queue of words still owed on the line; the front word is being
  // sent and idx counts its bits already presented. Two words queued means the
  // block is holding one, so it cannot take another.
  logic [W-1:0] wq[$];
  logic [W-1:0] acc_words[$];
  int           idx = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wq.delete();
      idx = 0;
    end else begin
      bit acc;
      acc = din_valid && (wq.size() < 2);
      if (wq.size() > 0) begin
        idx++;
        if (idx == W) begin
          void'(wq.pop_front());
          idx = 0;
        end
      end
      if (acc) begin
        wq.push_back(din);
        acc_words.push_back(din);
      end
    end
  end

  logic obs_m[$];
  logic obs_l[$];

  task automatic check_outputs();
    bit   act;
    logic eb_m, eb_l;
    act  = (wq.size() > 0);
    eb_m = act ? wq[0][W-1-idx] : 1'b0;
    eb_l = act ? wq[0][idx]     : 1'b0;
    chk("valid_m", sv_m,   act);
    chk("valid_l", sv_l,   act);
    chk("busy_m",  busy_m, act);
    chk("ready_m", rdy_m,  wq.size() < 2);
    chk("ready_l", rdy_l,  wq.size() < 2);
    chk("last_m",  sl_m,   act && (idx == W - 1));
    chk("last_l",  sl_l,   act && (idx == W - 1));
    chk("sout_m",  sout_m, eb_m);
    chk("sout_l",  sout_l, eb_l);
    if (sv_m) obs_m.push_back(sout_m);
    if (sv_l) obs_l.push_back(sout_l);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      check_outputs();
    end
  endtask

  function automatic logic [31:0] pack(input logic q[$]);
    logic [31:0] r;
    r = '0;
    foreach (q[i]) r = {r[30:0], q[i]};
    return r;
  endfunction

  task automatic clear_obs();
    obs_m.delete();
    obs_l.delete();
    acc_words.delete();
  endtask

  initial begin
    reset     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sout",  sout_m, 0);
    chk("rst_valid", sv_m,   0);
    chk("rst_last",  sl_m,   0);
    chk("rst_busy",  busy_m, 0);
    chk("rst_ready", rdy_m,  1);
    reset = 1'b0;
    cyc(2);

    // Single word
    clear_obs();
    din = 8'hB1; din_valid = 1'b1;
    cyc(1);
    din_valid = 1'b0;
    cyc(10);
    chk("single_len",  obs_m.size(), 8);
    chk("single_bits", pack(obs_m), 32'hB1);

    // Back-to-back with hold buffer
    clear_obs();
    din = 8'hB1; din_valid = 1'b1;
    cyc(1);
    din = 8'h0F;
    cyc(1);
    din_valid = 1'b0;
    chk("b2b_ready", rdy_m, 0);
    cyc(18);
    chk("b2b_len",  obs_m.size(), 16);
    chk("b2b_bits", pack(obs_m), 32'hB10F);

    // Bit order
    clear_obs();
    din = 8'h01; din_valid = 1'b1;
    cyc(1);
    din_valid = 1'b0;
    cyc(10);
    chk("lsb_bits", pack(obs_l), 32'h80);
    chk("msb_bits", pack(obs_m), 32'h01);

    // Reset during bit 4 with a word held
    clear_obs();
    din = 8'hFF; din_valid = 1'b1;
    cyc(1);
    din = 8'hAA;
    cyc(1);
    din_valid = 1'b0;
    cyc(2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_sout",  sout_m, 0);
    chk("mid_rst_valid", sv_m,   0);
    chk("mid_rst_last",  sl_m,   0);
    chk("mid_rst_busy",  busy_m, 0);
    chk("mid_rst_ready", rdy_m,  1);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    clear_obs();
    din = 8'h81; din_valid = 1'b1;
    cyc(1);
    din_valid = 1'b0;
    cyc(12);
    chk("post_rst_len",  obs_m.size(), 8);
    chk("post_rst_bits", pack(obs_m), 32'h81);

    // Backpressure: din keeps changing while the hold slot is full
    clear_obs();
    din_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      din = 8'($urandom);
      cyc(1);
    end
    din_valid = 1'b0;
    cyc(20);
    chk("bp_len", obs_m.size(), acc_words.size() * W);
    chk("bp_few", acc_words.size() < 30, 1);
    for (int i = 0; i < acc_words.size() && (i * W + W) <= obs_m.size(); i++) begin
      logic [W-1:0] got;
      got = '0;
      for (int b = 0; b < W; b++) got = {got[W-2:0], obs_m[i*W+b]};
      chk("bp_word", got, acc_words[i]);
    end

    // Stream feeding the pattern detector
    clear_obs();
    din = 8'h88; din_valid = 1'b1;
    cyc(1);
    din = 8'h80;
    cyc(1);
    din_valid = 1'b0;
    cyc(20);
    chk("chain_len",  obs_m.size(), 16);
    chk("chain_bits", pack(obs_m), 32'h8880);
    chk("chain_idle", sout_m, 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      din_valid = ($urandom_range(0, 2) != 0);
      din       = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
      end
      cyc(1);
    end
    din_valid = 1'b0;
    cyc(20);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
